add_mul_rr_scheduler: RTL and testbench
=======================================

# add_mul_rr_scheduler

Round-robin scheduler that shares one pipelined add-multiply unit, `out = (x + y) * z` modulo 2^WIDTH with fixed LATENCY and no stall input, among NUM_REQ requesters. It arbitrates valid/ready requests and drives the unit's operand ports. It tags each issue with the requester id and realigns tags with results. Completed results are buffered in a credit-protected response FIFO, so backpressure on the response port never loses a result.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 32, operand/result width
- LATENCY, 3, cycles from operands driven on pipe_x/y/z to result on pipe_out
- FIFO_DEPTH, 5, response FIFO entries (>=1; full throughput needs >= LATENCY+2)
- One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_x, req_y, req_z  in  NUM_REQ*WIDTH each  operands, requester i at bits [i*WIDTH +: WIDTH]
- pipe_x, pipe_y, pipe_z  out  WIDTH  operands to the shared unit
- pipe_out  in  WIDTH  result from the shared unit
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  clog2(NUM_REQ)  originating requester
- resp_data  out  WIDTH  result

## Operation
- Credits: `credit = FIFO_DEPTH - fifo_count - inflight`, computed from registered state at cycle start.
  - inflight = number of valid tag stages.
  - A FIFO pop in the same cycle does not add credit until the next cycle.
- Issue occurs when credit > 0, rst = 0 and any req_valid is high.
  - The grant goes to the first requester with valid set, scanning upward from last_grant+1 modulo NUM_REQ.
  - req_ready[g] = 1 for that cycle only. The handshake completes when req_valid and req_ready are both high.
  - last_grant updates only on issue.
- pipe_x/y/z carry the granted operands combinationally in the issue cycle. They are all-zero in non-issue cycles.
- Tag pipeline: LATENCY stages of {valid, id}.
  - tag[0] <= {issue, grant_id}; tag[k] <= tag[k-1].
  - tag[LATENCY-1].valid marks pipe_out as a live result in that cycle.
- Live result: {id, pipe_out} is pushed into the FIFO at the end of that cycle. The credit rule guarantees the FIFO is never full at push.
- FIFO head drives resp_valid/resp_id/resp_data.
  - Pop happens on resp_valid && resp_ready.
  - Simultaneous push and pop are allowed at any occupancy.
  - Order is strict issue order.
- Requesters hold req_valid and operands stable until accepted. A requester may drop req_valid before acceptance with no effect.
- req_ready never depends combinationally on resp_ready.
- Arithmetic: the result is (x+y)*z truncated to WIDTH bits, with no saturation or carry-out. The unit computes it; this block does not modify data.

## Timing
- Reset values:
  - req_ready = 0 and pipe_x/y/z = 0; req_ready is also forced 0 in every cycle rst is high.
  - resp_valid = 0; resp_id and resp_data = 0.
  - Tags invalid, FIFO empty, last_grant = NUM_REQ-1, so requester 0 has first priority.
- Latency: issue in cycle t → pipe_out live in t+LATENCY → resp_valid in t+LATENCY+1. With defaults, accept-to-response is 4 cycles.
- Throughput: one issue per cycle while resp_ready = 1 and FIFO_DEPTH >= LATENCY+2. With a smaller depth, issue bubbles follow directly from the credit rule.
- resp_ready low: issues continue until credit reaches 0 (FIFO_DEPTH results outstanding), then req_ready stays 0. Issue resumes the cycle after the first pop.
- Reset mid-operation:
  - All tags and FIFO contents are discarded. Datapath registers are not reset, so their stale results are ignored via the tags.
  - After rst falls, no resp_valid appears before a new issue plus LATENCY+1 cycles.
- A single requester held valid is granted every cycle, subject to credit. The pointer wraps from NUM_REQ-1 to 0.

## Test plan
- Single request: requester 2 issues x=3, y=4, z=5 at cycle 10 → resp_valid at cycle 14, resp_id=2, resp_data=35, popped that cycle with resp_ready=1.
- Fairness: all 4 requesters valid continuously, resp_ready=1 → grants 0,1,2,3,0,… one per cycle. Responses return in the same order with matching ids.
- Backpressure: resp_ready=0 with all requesters valid → exactly 5 issues, then req_ready=0. FIFO holds 5 entries. Raising resp_ready pops one per cycle and restarts issue with no loss or reorder.
- Wrap arithmetic: x=0xFFFFFFFF, y=1, z=7 → resp_data=0. Also x=0x80000000, y=0, z=2 → resp_data=0.
- Reset mid-flight: 3 issues in flight, rst high for 1 cycle → no resp_valid for any of them. req_ready=0 during rst. The first post-reset issue responds after 4 cycles.
- Credit edge: FIFO_DEPTH=1 build with continuous requests → one issue every LATENCY+2 cycles and never a dropped result.

Source files
------------

// File: rtl/add_mul_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined (x+y)*z unit among NUM_REQ requesters.
// Issue tags travel alongside the unit's pipeline; results land in a credit-protected response FIFO.
module add_mul_rr_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned FIFO_DEPTH = 5,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  input  logic [NUM_REQ*WIDTH-1:0] req_z,
  output logic [WIDTH-1:0]         pipe_x,
  output logic [WIDTH-1:0]         pipe_y,
  output logic [WIDTH-1:0]         pipe_z,
  input  logic [WIDTH-1:0]         pipe_out,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_data
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_found;
  logic                  issue;

  logic [LATENCY-1:0]    tag_valid;
  logic [ID_W-1:0]       tag_id [LATENCY];

  logic [ID_W+WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      inflight;
  logic                  credit_ok;
  logic                  push;
  logic                  pop;
  logic [ID_W+WIDTH-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outstanding work is everything in flight plus everything buffered; a pop this
  // cycle is deliberately not counted until the registered count reflects it.
  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      inflight = inflight + CNT_W'(tag_valid[k]);
    end
    credit_ok = (fifo_count + inflight) < CNT_W'(FIFO_DEPTH);
  end

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(last_grant) + k) % NUM_REQ;
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign issue     = !rst && credit_ok && grant_found;
  assign req_ready = issue ? (NUM_REQ'(1) << grant_id) : '0;
  assign pipe_x    = issue ? req_x[grant_id*WIDTH +: WIDTH] : '0;
  assign pipe_y    = issue ? req_y[grant_id*WIDTH +: WIDTH] : '0;
  assign pipe_z    = issue ? req_z[grant_id*WIDTH +: WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (issue) begin
      last_grant <= grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= issue;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      tag_id[k] <= tag_id[k-1];
    end
  end

  assign push = tag_valid[LATENCY-1];
  assign pop  = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {tag_id[LATENCY-1], pipe_out};
    end
  end

  assign head       = mem[rd_ptr];
  assign resp_valid = (fifo_count != '0);
  assign resp_id    = resp_valid ? head[ID_W+WIDTH-1:WIDTH] : '0;
  assign resp_data  = resp_valid ? head[WIDTH-1:0] : '0;

endmodule

// File: tb/tb_add_mul_rr_scheduler.sv
// Directed bench for add_mul_rr_scheduler: default build plus a FIFO_DEPTH=1 build,
// each driving its own behavioural (x+y)*z unit with a 3-cycle pipeline.
module tb_add_mul_rr_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_valid1;
  logic [3:0]   req_ready, req_ready1;
  logic [127:0] req_x, req_y, req_z;
  logic [31:0]  pipe_x, pipe_y, pipe_z, pipe_out;
  logic [31:0]  pipe_x1, pipe_y1, pipe_z1, pipe_out1;
  logic         resp_valid, resp_ready, resp_valid1, resp_ready1;
  logic [1:0]   resp_id, resp_id1;
  logic [31:0]  resp_data, resp_data1;

  logic [31:0]  u0 [3];
  logic [31:0]  u1 [3];
  logic [31:0]  fair_exp [4] = '{32'd22, 32'd36, 32'd52, 32'd70};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_mul_rr_scheduler #(.NUM_REQ(4), .WIDTH(32), .LATENCY(3), .FIFO_DEPTH(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_z(pipe_z), .pipe_out(pipe_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data)
  );

  add_mul_rr_scheduler #(.NUM_REQ(4), .WIDTH(32), .LATENCY(3), .FIFO_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .pipe_x(pipe_x1), .pipe_y(pipe_y1), .pipe_z(pipe_z1), .pipe_out(pipe_out1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_id(resp_id1), .resp_data(resp_data1)
  );

  // Shared arithmetic unit models: operands captured at the edge, result after 3 cycles.
  always @(posedge clk) begin
    u0[0] <= (pipe_x + pipe_y) * pipe_z;
    u1[0] <= (pipe_x1 + pipe_y1) * pipe_z1;
    for (int k = 1; k < 3; k++) begin
      u0[k] <= u0[k-1];
      u1[k] <= u1[k-1];
    end
  end
  assign pipe_out  = u0[2];
  assign pipe_out1 = u1[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    req_x[i*32 +: 32] = x;
    req_y[i*32 +: 32] = y;
    req_z[i*32 +: 32] = z;
  endtask

  task automatic set_fair_ops();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd10, 32'(i + 2));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_valid1 = '0;
    resp_ready = 1'b1; resp_ready1 = 1'b1;
    req_x = '0; req_y = '0; req_z = '0;

    // Reset: outputs quiet and req_ready forced low despite requests
    tick();
    req_valid = 4'hF; req_valid1 = 4'hF;
    settle();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_ready1", 64'(req_ready1), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_id", 64'(resp_id), 64'h0);
    chk("rst_resp_data", 64'(resp_data), 64'h0);
    chk("rst_pipe_x", 64'(pipe_x), 64'h0);
    tick();
    rst = 1'b0; req_valid = '0; req_valid1 = '0;

    // Single request from requester 2: (3+4)*5 = 35, response 4 cycles after accept
    set_op(2, 32'd3, 32'd4, 32'd5);
    req_valid = 4'b0100;
    settle();
    chk("single_ready", 64'(req_ready), 64'h4);
    chk("single_pipe_x", 64'(pipe_x), 64'd3);
    chk("single_pipe_y", 64'(pipe_y), 64'd4);
    chk("single_pipe_z", 64'(pipe_z), 64'd5);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      settle();
      chk("single_wait_valid", 64'(resp_valid), 64'h0);
      chk("single_idle_pipe", 64'(pipe_x), 64'h0);
      tick();
    end
    settle();
    chk("single_resp_valid", 64'(resp_valid), 64'h1);
    chk("single_resp_id", 64'(resp_id), 64'd2);
    chk("single_resp_data", 64'(resp_data), 64'd35);
    tick();
    settle();
    chk("single_popped", 64'(resp_valid), 64'h0);
    tick();

    // Wrap arithmetic; last grant was 2 so requester 3 is scanned first, then 0
    set_op(0, 32'hFFFF_FFFF, 32'd1, 32'd7);
    set_op(1, 32'h8000_0000, 32'd0, 32'd2);
    set_op(3, 32'h10, 32'h20, 32'h3);
    req_valid = 4'b0011;
    settle();
    chk("wrap_ready0", 64'(req_ready), 64'h1);
    chk("wrap_pipe_x0", 64'(pipe_x), 64'hFFFF_FFFF);
    tick();
    req_valid = 4'b1010;
    settle();
    chk("wrap_ready1", 64'(req_ready), 64'h2);
    chk("wrap_pipe_z1", 64'(pipe_z), 64'd2);
    tick();
    req_valid = 4'b1000;
    settle();
    chk("wrap_ready3", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    settle();
    chk("wrap_gap_valid", 64'(resp_valid), 64'h0);
    tick();
    settle();
    chk("wrap_r0_valid", 64'(resp_valid), 64'h1);
    chk("wrap_r0_id", 64'(resp_id), 64'd0);
    chk("wrap_r0_data", 64'(resp_data), 64'd0);
    tick();
    settle();
    chk("wrap_r1_id", 64'(resp_id), 64'd1);
    chk("wrap_r1_data", 64'(resp_data), 64'd0);
    tick();
    settle();
    chk("wrap_r3_id", 64'(resp_id), 64'd3);
    chk("wrap_r3_data", 64'(resp_data), 64'h90);
    tick();
    settle();
    chk("wrap_drained", 64'(resp_valid), 64'h0);
    tick();

    // Fairness: all valid for 8 cycles, grants 0,1,2,3,0,1,2,3, responses in order
    set_fair_ops();
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      settle();
      chk("fair_ready", 64'(req_ready), (k < 8) ? 64'(4'b1 << (k % 4)) : 64'h0);
      if (k < 4) begin
        chk("fair_early_valid", 64'(resp_valid), 64'h0);
      end else begin
        chk("fair_valid", 64'(resp_valid), 64'h1);
        chk("fair_id", 64'(resp_id), 64'((k - 4) % 4));
        chk("fair_data", 64'(resp_data), 64'(fair_exp[(k - 4) % 4]));
      end
      tick();
    end
    settle();
    chk("fair_drained", 64'(resp_valid), 64'h0);
    tick();

    // Backpressure: exactly 5 issues, then stall until the first pop
    resp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_valid = 4'hF;
      settle();
      chk("bp_ready", 64'(req_ready), (k < 5) ? 64'(4'b1 << (k % 4)) : 64'h0);
      if (k >= 4) begin
        chk("bp_valid", 64'(resp_valid), 64'h1);
        chk("bp_head_id", 64'(resp_id), 64'd0);
        chk("bp_head_data", 64'(resp_data), 64'd22);
      end
      tick();
    end
    resp_ready = 1'b1;
    for (int k = 10; k < 22; k++) begin
      req_valid = (k < 18) ? 4'hF : 4'h0;
      settle();
      chk("bp_resume_ready", 64'(req_ready),
          (k >= 11 && k < 18) ? 64'(4'b1 << ((k - 10) % 4)) : 64'h0);
      chk("bp_pop_valid", 64'(resp_valid), 64'h1);
      chk("bp_pop_id", 64'(resp_id), 64'((k - 10) % 4));
      chk("bp_pop_data", 64'(resp_data), 64'(fair_exp[(k - 10) % 4]));
      tick();
    end
    settle();
    chk("bp_drained", 64'(resp_valid), 64'h0);
    tick();

    // Reset with 3 results in flight: none may emerge; priority restarts at requester 0
    for (int k = 0; k < 11; k++) begin
      rst = (k == 3);
      req_valid = (k < 4 || k == 5) ? 4'hF : 4'h0;
      settle();
      if (k < 3)  chk("rstmid_ready", 64'(req_ready), 64'(4'b1 << k));
      if (k == 3) begin
        chk("rstmid_ready_in_rst", 64'(req_ready), 64'h0);
        chk("rstmid_pipe_in_rst", 64'(pipe_x), 64'h0);
      end
      if (k == 5) chk("rstmid_first_grant", 64'(req_ready), 64'h1);
      if (k >= 3 && k < 9) chk("rstmid_no_resp", 64'(resp_valid), 64'h0);
      if (k == 9) begin
        chk("rstmid_resp_valid", 64'(resp_valid), 64'h1);
        chk("rstmid_resp_id", 64'(resp_id), 64'd0);
        chk("rstmid_resp_data", 64'(resp_data), 64'd22);
      end
      if (k == 10) chk("rstmid_drained", 64'(resp_valid), 64'h0);
      tick();
    end
    rst = 1'b0;
    req_valid = '0;

    // FIFO_DEPTH=1 build: one issue every LATENCY+2 cycles, nothing dropped
    for (int k = 0; k < 20; k++) begin
      req_valid1 = (k < 16) ? 4'hF : 4'h0;
      settle();
      chk("d1_ready", 64'(req_ready1),
          (k % 5 == 0 && k < 16) ? 64'(4'b1 << (k / 5)) : 64'h0);
      if (k % 5 == 4) begin
        chk("d1_valid", 64'(resp_valid1), 64'h1);
        chk("d1_id", 64'(resp_id1), 64'(k / 5));
        chk("d1_data", 64'(resp_data1), 64'(fair_exp[k / 5]));
      end else begin
        chk("d1_idle", 64'(resp_valid1), 64'h0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
